// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin arbiter sharing one AXI Stream sink among NUM_PORTS sources.
// Define AXIS_ARB_TID_EN to add m_axis_tid_o carrying the granted source index.
module axis_rr_arbiter #(
    parameter int  NUM_PORTS   = 4,
    parameter int  DATA_WIDTH  = 8,
    localparam int GRANT_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                            clk_i,
    input  logic                            arstn_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid_i,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast_i,
    output logic [NUM_PORTS-1:0]            s_axis_tready_o,
    input  logic                            m_axis_tready_i,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata_o,
    output logic                            m_axis_tvalid_o,
    output logic                            m_axis_tlast_o,
    output logic [GRANT_WIDTH-1:0]          grant_o,
    output logic                            busy_o
`ifdef AXIS_ARB_TID_EN
    ,
    output logic [GRANT_WIDTH-1:0]          m_axis_tid_o
`endif
);
    typedef enum logic {IDLE, XFER} state_t;
    state_t                 state, state_next;
    logic [GRANT_WIDTH-1:0] grant, grant_next, last_grant, last_grant_next, winner;
    int                     idx;
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GRANT_WIDTH'(NUM_PORTS - 1);
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
        end
    end
    // Scan downward so the port closest after last_grant is the final assignment.
    always_comb begin
        winner = grant;
        idx    = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (s_axis_tvalid_i[GRANT_WIDTH'(idx)]) winner = GRANT_WIDTH'(idx);
        end
    end
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        if (state == IDLE && |s_axis_tvalid_i) begin
            state_next = XFER;
            grant_next = winner;
        end
        if (state == XFER && m_axis_tvalid_o && m_axis_tready_i && m_axis_tlast_o) begin
            state_next      = IDLE;
            last_grant_next = grant;
        end
    end
    assign busy_o          = state == XFER;
    assign grant_o         = grant;
    assign m_axis_tvalid_o = busy_o & s_axis_tvalid_i[grant];
    assign m_axis_tlast_o  = busy_o & s_axis_tlast_i[grant];
    assign m_axis_tdata_o  = busy_o ? s_axis_tdata_i[grant*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign s_axis_tready_o = busy_o ? NUM_PORTS'(m_axis_tready_i) << grant : '0;
`ifdef AXIS_ARB_TID_EN
    assign m_axis_tid_o    = busy_o ? grant : '0;
`endif
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: random and directed stimulus checked every cycle against a packet-level arbiter model.
module tb_axis_rr_arbiter;
    localparam int N = 4;
    logic         clk = 0, rstn = 0, m_ready = 0;
    logic [N-1:0] v = '0, l = '0;
    logic [7:0]   d [N];
    logic [N*8-1:0] dv;
    logic [N-1:0] tready;
    logic [7:0]   mdata;
    logic         mvalid, mlast, busy;
    logic [1:0]   grant;
`ifdef AXIS_ARB_TID_EN
    logic [1:0]   tid;
`endif
    int n_chk = 0, n_pass = 0;
    int m_owner = -1, m_last = N - 1, m_gnt = 0;
    bit armed = 0, auto_src = 0;
    int rem [N], seq [N];
    int pct = 100, flen = 2;
    int gseq [$];
    logic [7:0] got [$];
    int rr_exp [5] = '{0, 1, 2, 3, 0};

    axis_rr_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .arstn_i(rstn), .s_axis_tdata_i(dv), .s_axis_tvalid_i(v),
        .s_axis_tlast_i(l), .s_axis_tready_o(tready), .m_axis_tready_i(m_ready),
        .m_axis_tdata_o(mdata), .m_axis_tvalid_o(mvalid), .m_axis_tlast_o(mlast),
        .grant_o(grant),
`ifdef AXIS_ARB_TID_EN
        .m_axis_tid_o(tid),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always_comb for (int p = 0; p < N; p++) dv[p*8 +: 8] = d[p];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [N-1:0] exp_tready();
        return (m_owner >= 0 && m_ready) ? (N'(1) << m_owner) : '0;
    endfunction

    // Outputs follow directly from who owns the sink this cycle.
    task automatic settle();
        bit own;
        int o;
        #1;
        if (armed) begin
            own = m_owner >= 0;
            o   = own ? m_owner : 0;
            chk("busy", busy, own);
            chk("grant", grant, m_gnt);
            chk("tready", tready, exp_tready());
            chk("m_valid", mvalid, own & v[o]);
            chk("m_last", mlast, own & l[o]);
            chk("m_data", mdata, own ? d[o] : 8'h0);
`ifdef AXIS_ARB_TID_EN
            chk("tid", tid, own ? m_gnt : 0);
`endif
        end
    endtask

    task automatic drive_src();
        for (int p = 0; p < N; p++) begin
            if (!v[p] && $urandom_range(99) < pct) begin
                if (rem[p] <= 0) rem[p] = flen > 0 ? flen : int'($urandom_range(4, 1));
                v[p] = 1;
            end
            d[p] = 8'((p << 6) | (seq[p] & 63));
            l[p] = rem[p] == 1;
        end
    endtask

    task automatic tick();
        logic [N-1:0] hs;
        hs = v & exp_tready();
        @(posedge clk);
        if (!rstn) begin
            m_owner = -1; m_last = N - 1; m_gnt = 0; armed = 1;
        end else if (m_owner < 0) begin
            if (|v) begin
                for (int k = N; k >= 1; k--) if (v[(m_last + k) % N]) m_owner = (m_last + k) % N;
                m_gnt = m_owner;
            end
        end else if (v[m_owner] && m_ready && l[m_owner]) begin
            m_last = m_owner; m_owner = -1;
        end
        @(negedge clk);
        if (auto_src) begin
            for (int p = 0; p < N; p++) if (hs[p]) begin seq[p]++; rem[p]--; v[p] = 0; end
            drive_src();
        end
    endtask

    task automatic do_reset();
        auto_src = 0; rstn = 0; v = '0; l = '0; m_ready = 0;
        for (int p = 0; p < N; p++) begin rem[p] = 0; seq[p] = 0; d[p] = 8'h0; end
        tick(); tick();
        rstn = 1;
    endtask

    initial begin
        int nb;
        bit pb;
        for (int p = 0; p < N; p++) d[p] = 8'h0;
        @(negedge clk);
        rstn = 0; tick(); tick(); settle();
        chk("rst_tready", tready, 0); chk("rst_valid", mvalid, 0);
        chk("rst_busy", busy, 0); chk("rst_grant", grant, 0);
        rstn = 1;
        // single requester, port 2
        m_ready = 1; v[2] = 1; d[2] = 8'hA1; l[2] = 0;
        settle(); chk("sr_arb_busy", busy, 0); tick();
        for (int b = 0; b < 3; b++) begin
            d[2] = 8'(8'hA1 + b); l[2] = b == 2;
            settle();
            chk("sr_grant", grant, 2); chk("sr_data", mdata, 8'hA1 + b); chk("sr_last", mlast, b == 2);
            tick();
        end
        v[2] = 0; l[2] = 0;
        settle(); chk("sr_done_busy", busy, 0); chk("sr_hold_grant", grant, 2); tick();
        // fairness with every port streaming 2-beat packets
        do_reset(); m_ready = 1; pct = 100; flen = 2; auto_src = 1; drive_src();
        pb = 0;
        for (int c = 0; c < 16; c++) begin
            settle();
            if (busy && !pb) gseq.push_back(int'(grant));
            pb = busy;
            tick();
        end
        auto_src = 0;
        for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), i < gseq.size() ? gseq[i] : -1, rr_exp[i]);
        // backpressure and source stall on port 1 with port 0 waiting
        do_reset(); m_ready = 1; v[1] = 1; d[1] = 8'hB1; l[1] = 0;
        settle(); tick();
        v[0] = 1; d[0] = 8'h55; l[0] = 1; nb = 0;
        for (int c = 0; c < 20 && nb < 4; c++) begin
            m_ready = c % 2 == 0;
            v[1] = !(c == 2 || c == 3);
            d[1] = 8'(8'hB1 + nb); l[1] = nb == 3;
            settle();
            chk("bp_grant", grant, 1);
            if (mvalid && m_ready) got.push_back(mdata);
            if (v[1] && m_ready) nb++;
            tick();
        end
        v[1] = 0; l[1] = 0; m_ready = 1;
        chk("bp_beats", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_data", i < got.size() ? got[i] : 8'h0, 8'hB1 + i);
        settle(); chk("bp_gap", busy, 0); tick();
        settle(); chk("bp_next_grant", grant, 0); chk("bp_next_busy", busy, 1); tick();
        // reset in the middle of a port 3 packet
        do_reset(); m_ready = 1; v[3] = 1; d[3] = 8'hC1; l[3] = 0;
        settle(); tick();
        for (int b = 0; b < 2; b++) begin d[3] = 8'(8'hC1 + b); settle(); tick(); end
        d[3] = 8'hC3; v[0] = 1; d[0] = 8'h05; l[0] = 0; rstn = 0;
        settle(); tick();
        rstn = 1;
        settle(); chk("mr_busy", busy, 0); chk("mr_grant", grant, 0); tick();
        settle(); chk("mr_win", grant, 0); chk("mr_win_busy", busy, 1); chk("mr_data", mdata, 8'h05); tick();
        // random traffic, ragged sources, random sink, rare resets
        do_reset(); pct = 40; flen = 0; auto_src = 1; drive_src();
        for (int c = 0; c < 3000; c++) begin
            m_ready = $urandom_range(99) < 70;
            rstn = $urandom_range(999) != 0;
            settle();
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
